// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: write-back stage driving the register-file write port; holds loads until memory responds or times out.
// Optional macro WB_BYPASS_EN adds a combinational write-to-read forwarding path.
module reg_writeback_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_REG    = 31,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_RegWrite,
    input  logic              in_MemtoReg,
    input  logic              in_link,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_pc_plus4,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0] read_addr_1,
    input  logic [ADDR_W-1:0] read_addr_2,
    input  logic [DATA_W-1:0] rf_data_1,
    input  logic [DATA_W-1:0] rf_data_2,
    output logic [DATA_W-1:0] fwd_data_1,
    output logic [DATA_W-1:0] fwd_data_2,
`endif
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              load_timeout
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [0:0]        state;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] ld_dest;
    logic              ld_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic              c_we;

    assign in_ready = state == IDLE;
    assign busy     = state == WAIT_MEM;

    always_comb begin
        c_addr = in_link ? ADDR_W'(LINK_REG) : in_dest;
        c_data = in_link ? in_pc_plus4 : in_alu_result;
        c_we   = in_link | in_RegWrite;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ld_dest      <= '0;
            ld_we        <= 1'b0;
            RegWrite     <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            load_timeout <= 1'b0;
        end else begin
            RegWrite     <= 1'b0;
            load_timeout <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && in_MemtoReg && !in_link) begin
                    state   <= WAIT_MEM;
                    ld_dest <= in_dest;
                    ld_we   <= in_RegWrite;
                    cnt     <= '0;
                end else if (in_valid) begin
                    RegWrite   <= c_we && c_addr != '0;
                    write_addr <= c_addr;
                    write_data <= c_data;
                end
            end else if (mem_rvalid) begin
                // data arriving on the last counted cycle still commits
                state      <= IDLE;
                RegWrite   <= ld_we && ld_dest != '0;
                write_addr <= ld_dest;
                write_data <= mem_rdata;
            end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
                state        <= IDLE;
                load_timeout <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd_data_1 = (RegWrite && read_addr_1 != '0 && write_addr == read_addr_1) ? write_data : rf_data_1;
    assign fwd_data_2 = (RegWrite && read_addr_2 != '0 && write_addr == read_addr_2) ? write_data : rf_data_2;
`endif
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed self-checking bench for reg_writeback_unit.
module tb_reg_writeback_unit;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_RegWrite = 1'b0;
    logic        in_MemtoReg = 1'b0;
    logic        in_link = 1'b0;
    logic [4:0]  in_dest = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_pc_plus4 = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        RegWrite;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        busy;
    logic        load_timeout;
`ifdef WB_BYPASS_EN
    logic [4:0]  read_addr_1 = '0;
    logic [4:0]  read_addr_2 = '0;
    logic [31:0] rf_data_1 = '0;
    logic [31:0] rf_data_2 = '0;
    logic [31:0] fwd_data_1;
    logic [31:0] fwd_data_2;
`endif
    int checks = 0;
    int failures = 0;
    logic bad;

    always #5 clk = ~clk;

    reg_writeback_unit #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg), .in_link(in_link),
        .in_dest(in_dest), .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
`ifdef WB_BYPASS_EN
        .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
        .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
        .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
`endif
        .RegWrite(RegWrite), .write_addr(write_addr), .write_data(write_data),
        .busy(busy), .load_timeout(load_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic m2r, input logic lnk, input logic [4:0] d,
                         input logic [31:0] alu, input logic [31:0] pc);
        in_valid = 1'b1; in_RegWrite = we; in_MemtoReg = m2r; in_link = lnk;
        in_dest = d; in_alu_result = alu; in_pc_plus4 = pc;
        tick();
        in_valid = 1'b0; in_RegWrite = 1'b0; in_MemtoReg = 1'b0; in_link = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_addr", 32'(write_addr), 32'd0);
        chk("rst_data", write_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(load_timeout), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        issue(1'b1, 1'b0, 1'b0, 5'd8, 32'h1234, 32'h0);
        chk("alu_we", 32'(RegWrite), 32'd1);
        chk("alu_addr", 32'(write_addr), 32'd8);
        chk("alu_data", write_data, 32'h1234);
        tick();
        chk("alu_pulse_end", 32'(RegWrite), 32'd0);

        issue(1'b1, 1'b0, 1'b0, 5'd3, 32'hA, 32'h0);
        chk("b2b_first_addr", 32'(write_addr), 32'd3);
        issue(1'b1, 1'b0, 1'b0, 5'd4, 32'hB, 32'h0);
        chk("b2b_second_we", 32'(RegWrite), 32'd1);
        chk("b2b_second_data", write_data, 32'hB);
        tick();

        mem_rvalid = 1'b1; mem_rdata = 32'h5555;
        issue(1'b1, 1'b1, 1'b0, 5'd9, 32'hBAD, 32'h0);
        mem_rvalid = 1'b0;
        chk("load_ready_low", 32'(in_ready), 32'd0);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_no_early_we", 32'(RegWrite), 32'd0);
        tick(); tick();
        chk("load_still_busy", 32'(busy), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rvalid = 1'b0;
        chk("load_we", 32'(RegWrite), 32'd1);
        chk("load_addr", 32'(write_addr), 32'd9);
        chk("load_data", write_data, 32'hDEADBEEF);
        chk("load_idle", 32'(in_ready), 32'd1);
        tick();
        chk("load_pulse_end", 32'(RegWrite), 32'd0);

        issue(1'b0, 1'b1, 1'b1, 5'd7, 32'h99, 32'h40);
        chk("jal_we", 32'(RegWrite), 32'd1);
        chk("jal_addr", 32'(write_addr), 32'd31);
        chk("jal_data", write_data, 32'h40);
        chk("jal_ready", 32'(in_ready), 32'd1);

        issue(1'b1, 1'b0, 1'b0, 5'd0, 32'h55, 32'h0);
        chk("r0_we", 32'(RegWrite), 32'd0);
        chk("r0_addr", 32'(write_addr), 32'd0);
        chk("r0_data", write_data, 32'h55);

        issue(1'b0, 1'b0, 1'b0, 5'd6, 32'h66, 32'h0);
        chk("nowe_we", 32'(RegWrite), 32'd0);
        chk("nowe_data", write_data, 32'h66);

        issue(1'b1, 1'b1, 1'b0, 5'd10, 32'h0, 32'h0);
        bad = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (!busy || RegWrite || load_timeout) bad = 1'b1;
        end
        chk("to_waiting", 32'(bad), 32'd0);
        tick();
        chk("to_pulse", 32'(load_timeout), 32'd1);
        chk("to_no_we", 32'(RegWrite), 32'd0);
        chk("to_idle", 32'(busy), 32'd0);
        tick();
        chk("to_pulse_end", 32'(load_timeout), 32'd0);

        issue(1'b1, 1'b1, 1'b0, 5'd11, 32'h0, 32'h0);
        for (int i = 0; i < TO - 1; i++) tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hC0FFEE;
        tick();
        mem_rvalid = 1'b0;
        chk("edge_we", 32'(RegWrite), 32'd1);
        chk("edge_data", write_data, 32'hC0FFEE);
        chk("edge_no_timeout", 32'(load_timeout), 32'd0);
        tick();

        issue(1'b0, 1'b1, 1'b0, 5'd13, 32'h0, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1313;
        tick();
        mem_rvalid = 1'b0;
        chk("ldnowe_we", 32'(RegWrite), 32'd0);
        chk("ldnowe_addr", 32'(write_addr), 32'd13);
        chk("ldnowe_data", write_data, 32'h1313);

        issue(1'b1, 1'b1, 1'b0, 5'd12, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_ready", 32'(in_ready), 32'd1);
        chk("rstmid_busy", 32'(busy), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h7777;
        tick();
        mem_rvalid = 1'b0;
        chk("rstmid_no_we", 32'(RegWrite), 32'd0);
        chk("rstmid_no_timeout", 32'(load_timeout), 32'd0);
        chk("rstmid_ready2", 32'(in_ready), 32'd1);

`ifdef WB_BYPASS_EN
        read_addr_1 = 5'd5; rf_data_1 = 32'h11;
        read_addr_2 = 5'd6; rf_data_2 = 32'h22;
        issue(1'b1, 1'b0, 1'b0, 5'd5, 32'h77, 32'h0);
        chk("fwd1_hit", fwd_data_1, 32'h77);
        chk("fwd2_miss", fwd_data_2, 32'h22);
        tick();
        chk("fwd1_idle", fwd_data_1, 32'h11);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
